// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: operation encoding and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_e;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/alu_exec.sv
// Combinational ALU core: (op, A, B) -> (result, {V,C,N,Z}).
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl_full;
  logic [WIDTH:0]   shr_full;
  logic [WIDTH:0]   sra_full;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  assign shamt = b_i[SHW-1:0];
  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};

  // One guard bit on the exit side of each shift captures the last bit shifted
  // out; it is naturally 0 for a zero amount or once only fill bits leave.
  assign shl_full = {1'b0, a_i} << shamt;
  assign shr_full = {a_i, 1'b0} >> shamt;
  assign sra_full = $signed({a_i, 1'b0}) >>> shamt;

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (op_i)
      ALU_ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_SUB: begin
        res   = diff[WIDTH-1:0];
        carry = diff[WIDTH];
        ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_AND: res = a_i & b_i;
      ALU_OR:  res = a_i | b_i;
      ALU_XOR: res = a_i ^ b_i;
      ALU_SHL: begin
        res   = shl_full[WIDTH-1:0];
        carry = shl_full[WIDTH];
      end
      ALU_SHR: begin
        res   = shr_full[WIDTH:1];
        carry = shr_full[0];
      end
      ALU_SRA: begin
        res   = sra_full[WIDTH:1];
        carry = sra_full[0];
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_Z] = (res == '0);
    flags_o[FLAG_N] = res[WIDTH-1];
    flags_o[FLAG_C] = carry;
    flags_o[FLAG_V] = ovf;
  end

  assign result_o = res;

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage ALU pipeline: S1 holds the request, S2 holds the computed response.
// Both ends use valid/ready; back-pressure propagates combinationally from rsp_ready.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  alu_op_e          opcode,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [TAG_W-1:0] rsp_tag
);

  logic             s1_valid_q, s1_valid_d;
  alu_op_e          s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_res_q,   s2_res_d;
  logic [3:0]       s2_flags_q, s2_flags_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

  logic             adv1;
  logic             adv2;
  logic [WIDTH-1:0] exe_res;
  logic [3:0]       exe_flags;

  alu_exec #(
    .WIDTH(WIDTH)
  ) u_exec (
    .op_i     (s1_op_q),
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .result_o (exe_res),
    .flags_o  (exe_flags)
  );

  // A stage may advance when it is empty or the stage after it is advancing.
  assign adv2      = !s2_valid_q || rsp_ready;
  assign adv1      = !s1_valid_q || adv2;
  assign req_ready = adv1;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_flags_d = s2_flags_q;
    s2_tag_d   = s2_tag_q;

    if (adv1) begin
      s1_valid_d = req_valid;
      if (req_valid) begin
        s1_op_d  = opcode;
        s1_a_d   = operandA;
        s1_b_d   = operandB;
        s1_tag_d = req_tag;
      end
    end

    // Payload only changes on a real transfer so stalled outputs stay put.
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d   = exe_res;
        s2_flags_d = exe_flags;
        s2_tag_d   = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= ALU_ADD;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_flags_q <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_flags_q <= s2_flags_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign result    = s2_res_q;
  assign flags     = s2_flags_q;
  assign rsp_tag   = s2_tag_q;

endmodule

// File: doc/pipelined_alu.md
Name: pipelined_alu

Overview:
- Second-generation ALU: parametrised width, 8 operations, status flags, and a transaction tag passed through unchanged.
- Two-stage pipeline with valid/ready handshakes on both input and output; back-pressure stalls the pipeline without losing data.
- Sits between a request producer (sequencer/bus adapter) and a response consumer, with full throughput of one op per cycle.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..64.
- TAG_W, 4, width of the transaction tag carried from request to response; minimum 1.

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low (0 = reset)
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- operandA  in  WIDTH  first operand
- operandB  in  WIDTH  second operand; low $clog2(WIDTH) bits are the shift amount for shift ops
- opcode  in  3  operation select (alu_pkg::alu_op_e)
- req_tag  in  TAG_W  request identifier
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- result  out  WIDTH  operation result
- flags  out  4  {V,C,N,Z}: overflow, carry/borrow, negative, zero
- rsp_tag  out  TAG_W  tag of the request that produced this response

Behaviour:
- Reset (reset=0, asynchronous): s1_valid=0, s2_valid=0, rsp_valid=0, result=0, flags=0, rsp_tag=0. In-flight ops are discarded. req_ready=1 during the first cycle after release.
- Handshakes: a request transfers when req_valid && req_ready; a response transfers when rsp_valid && rsp_ready.
- Stage 1 (S1) registers opcode, operands and tag.
- Stage 2 (S2) registers the computed result, flags and tag, and drives the outputs.
- Advance rules:
  - adv2 = !s2_valid || rsp_ready
  - adv1 = !s1_valid || adv2
  - req_ready = adv1, which is combinational from rsp_ready. No combinational path exists from req_valid to req_ready.
- Latency: 2 cycles from the accept edge to rsp_valid when rsp_ready is held high. Throughput is 1 op/cycle.
- While rsp_valid && !rsp_ready: result, flags and rsp_tag hold stable. S1 holds if it is occupied. Nothing is dropped or duplicated.
- Ops:
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL: logical left
  - 6 SHR: logical right
  - 7 SRA: arithmetic right
- Shift amount is operandB[$clog2(WIDTH)-1:0]. Amounts >= WIDTH (WIDTH not a power of 2) give 0 for SHL/SHR and all-sign-bits for SRA.
- Flags:
  - Z: result==0 (all ops).
  - N: result[WIDTH-1] (all ops).
  - C: ADD carry-out of bit WIDTH-1; SUB borrow, i.e. 1 when A<B unsigned; SHL the last bit shifted out of the MSB; SHR/SRA the last bit shifted out of the LSB; C=0 for logic ops and for zero shift amount.
  - V: ADD/SUB signed overflow only (two's complement); 0 otherwise.
- Arithmetic is modulo 2^WIDTH. Operands are unsigned except for the V and SRA definitions.
- Simultaneous accept and drain in the same cycle: both occur, and occupancy is unchanged.
- Reset asserted mid-stall: all state clears immediately; the consumer sees rsp_valid fall asynchronously.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum logic [2:0] alu_op_e {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_SRA}.
  - Flag index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3.
- Sub-module alu_exec: purely combinational, parametrised by WIDTH, (op, A, B) -> (result, flags). It is instantiated between S1 and S2, so it can be unit-tested alone.

Test Plan:
- Reset then single ops (WIDTH=8, rsp_ready=1):
  - ADD 0xFF+0x01, tag 3 -> result 0x00, Z=1, C=1, V=0, rsp_tag 3, exactly 2 cycles after accept.
  - ADD 0x7F+0x01 -> 0x80, N=1, V=1, C=0.
  - SUB 0x10-0x20 -> 0xF0, C=1 (borrow), N=1.
  - SUB 0x80-0x01 -> 0x7F, V=1.
- Shifts:
  - SHL 0x81 by 1 -> 0x02, C=1.
  - SHR 0x81 by 1 -> 0x40, C=1.
  - SRA 0x80 by 7 -> 0xFF, N=1.
  - Shift by 0 -> operand unchanged, C=0.
- Streaming:
  - 16 back-to-back requests with tags 0..15 and rsp_ready=1 -> req_ready constantly 1.
  - 16 responses in order on consecutive cycles, with correct results.
- Back-pressure:
  - Drop rsp_ready for 5 cycles mid-stream -> req_ready falls once S1 and S2 are full.
  - Outputs hold stable during the stall.
  - After release, no tag is lost or duplicated and order is preserved.
- Async reset:
  - Assert reset between clock edges with 2 ops in flight -> rsp_valid and the other outputs go to 0 without a clock.
  - After release, a new ADD 2+3 returns 0x05 with its own tag.
